// File: rtl/disp_pkg.sv
// -----------------------------------------------------------------------------
// disp_pkg
//   Shared helpers for the round-robin dispatcher and its picker.
//
//   pw_of(w)       : width of a port pointer for w ports (at least 1 bit).
//   onehot2idx(oh) : binary index of the set bit in a one-hot vector
//                    (returns 0 for an all-zero vector).
//
//   One-hot vectors are handled zero-extended to OH_MAXW bits, so port
//   counts up to OH_MAXW are supported.
// -----------------------------------------------------------------------------
package disp_pkg;

   localparam int OH_MAXW = 32;

   typedef logic [OH_MAXW-1:0] oh_t;

   function automatic int pw_of(input int w);
      return $clog2((w > 1) ? w : 2);
   endfunction

   function automatic logic [31:0] onehot2idx(input oh_t oh);
      logic [31:0] idx;
      idx = 32'd0;
      for (int i = 0; i < OH_MAXW; i++) begin
         if (oh[i]) begin
            idx = idx | 32'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker. Finds the first set bit of acc,
//   searching from position ptr upwards and wrapping to 0.
//
//   Ports:
//     acc  in  WIDTH  candidate mask (bit i = candidate i available)
//     ptr  in  PW     search start position (0..WIDTH-1)
//     sel  out WIDTH  one-hot winner (all zero when acc is zero)
//     idx  out PW     binary index of the winner
//     any  out 1      at least one candidate available
// -----------------------------------------------------------------------------
module rr_pick
   import disp_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int PW    = pw_of(WIDTH)
) (
   input  logic [WIDTH-1:0] acc,
   input  logic [PW-1:0]    ptr,
   output logic [WIDTH-1:0] sel,
   output logic [PW-1:0]    idx,
   output logic             any
);

   localparam logic [2*WIDTH-1:0] ONE = {{(2*WIDTH-1){1'b0}}, 1'b1};

   logic [2*WIDTH-1:0] dbl;
   logic [2*WIDTH-1:0] iso;

   // Double-width trick: the lower copy of acc is masked below ptr, the
   // upper copy stays whole so wrap-around candidates appear above it. The
   // lowest remaining set bit is then the round-robin winner; folding both
   // halves together turns it back into a WIDTH-bit one-hot.
   always_comb begin
      dbl = {acc, acc} & ~((ONE << ptr) - ONE);
      iso = dbl & (~dbl + ONE);
      sel = iso[WIDTH-1:0] | iso[2*WIDTH-1:WIDTH];
      idx = PW'(onehot2idx(oh_t'(sel)));
      any = |acc;
   end

endmodule

// File: rtl/disp_rr.sv
// -----------------------------------------------------------------------------
// disp_rr
//   Round-robin dispatcher: one valid/ready input stream fanned out over WIDTH
//   consumer ports, each behind a one-entry register slice. A beat goes to the
//   first port able to take it, starting from the rotating pointer.
//
//   Ports:
//     clk       in   1         clock
//     rst       in   1         asynchronous reset, active high
//     in_vld    in   1         input beat valid
//     in_data   in   DW        input beat payload
//     in_rdy    out  1         a beat can be accepted this cycle
//     out_vld   out  WIDTH     per-port valid
//     out_data  out  WIDTH*DW  per-port payload, port i at [i*DW +: DW]
//     out_rdy   in   WIDTH     per-port consumer ready
//     v_sel     out  WIDTH     one-hot port receiving a beat this cycle
// -----------------------------------------------------------------------------
module disp_rr
   import disp_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DW    = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_vld,
   input  logic [DW-1:0]       in_data,
   output logic                in_rdy,
   output logic [WIDTH-1:0]    out_vld,
   output logic [WIDTH*DW-1:0] out_data,
   input  logic [WIDTH-1:0]    out_rdy,
   output logic [WIDTH-1:0]    v_sel
);

   localparam int PW = pw_of(WIDTH);

   logic [PW-1:0]    ptr;
   logic [PW-1:0]    ptr_next;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] pick_sel;
   logic [PW-1:0]    pick_idx;
   logic             pick_any;
   logic             accept;

   // A slot can take a beat when it is empty or being drained this cycle.
   always_comb begin
      acc = ~out_vld | out_rdy;
   end

   rr_pick #(
      .WIDTH (WIDTH),
      .PW    (PW)
   ) u_pick (
      .acc (acc),
      .ptr (ptr),
      .sel (pick_sel),
      .idx (pick_idx),
      .any (pick_any)
   );

   // Handshake glue; in_rdy depends only on slot state, never on in_vld.
   always_comb begin
      in_rdy = pick_any;
      accept = in_vld & pick_any;
      if (accept) begin
         v_sel = pick_sel;
      end else begin
         v_sel = {WIDTH{1'b0}};
      end
   end

   // Pointer moves to the port after the one just served, wrapping at WIDTH.
   always_comb begin
      ptr_next = ptr;
      if (accept) begin
         if (pick_idx == PW'(WIDTH - 1)) begin
            ptr_next = {PW{1'b0}};
         end else begin
            ptr_next = pick_idx + PW'(1);
         end
      end else begin
         ptr_next = ptr;
      end
   end

   // Round-robin pointer register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= {PW{1'b0}};
      end else begin
         ptr <= ptr_next;
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_slot
      // One-entry slice: a refill wins over a drain so a port being emptied
      // and refilled in the same cycle stays valid with no bubble.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            out_vld[i]            <= 1'b0;
            out_data[i*DW +: DW]  <= {DW{1'b0}};
         end else if (v_sel[i]) begin
            out_vld[i]            <= 1'b1;
            out_data[i*DW +: DW]  <= in_data;
         end else if (out_rdy[i]) begin
            out_vld[i]            <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_disp_rr.sv
// -----------------------------------------------------------------------------
// tb_disp_rr
//   Directed bench for disp_rr: a WIDTH=4/DW=32 instance driven through the
//   rotation, back-pressure, skip, refill and reset scenarios plus a random
//   out_rdy soak, and a WIDTH=3/DW=8 instance for non-power-of-two wrap.
// -----------------------------------------------------------------------------
module tb_disp_rr;

   logic         clk;
   logic         rst;

   logic         in_vld;
   logic [31:0]  in_data;
   logic         in_rdy;
   logic [3:0]   out_vld;
   logic [127:0] out_data;
   logic [3:0]   out_rdy;
   logic [3:0]   v_sel;

   logic         in_vld2;
   logic [7:0]   in_data2;
   logic         in_rdy2;
   logic [2:0]   out_vld2;
   logic [23:0]  out_data2;
   logic [2:0]   out_rdy2;
   logic [2:0]   v_sel2;

   int checks = 0;
   int errors = 0;

   // reference model state for the 4-port instance
   logic [3:0]   mvld;
   logic [127:0] mdata;
   int           mptr;
   logic [3:0]   last_sel;

   disp_rr #(.WIDTH(4), .DW(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_vld   (in_vld),
      .in_data  (in_data),
      .in_rdy   (in_rdy),
      .out_vld  (out_vld),
      .out_data (out_data),
      .out_rdy  (out_rdy),
      .v_sel    (v_sel)
   );

   disp_rr #(.WIDTH(3), .DW(8)) dut3 (
      .clk      (clk),
      .rst      (rst),
      .in_vld   (in_vld2),
      .in_data  (in_data2),
      .in_rdy   (in_rdy2),
      .out_vld  (out_vld2),
      .out_data (out_data2),
      .out_rdy  (out_rdy2),
      .v_sel    (v_sel2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // One cycle on the 4-port instance. Inputs are applied just after a
   // rising edge, combinational outputs are checked against the model before
   // the next edge, registered outputs one time unit after it.
   task automatic cyc(input logic v, input logic [31:0] d, input logic [3:0] r);
      logic [3:0] macc;
      logic [3:0] esel;
      int         tgt;
      in_vld  = v;
      in_data = d;
      out_rdy = r;
      #1;
      macc = ~mvld | r;
      esel = 4'b0000;
      tgt  = 0;
      for (int k = 0; k < 4; k++) begin
         int j;
         j = (mptr + k) % 4;
         if (macc[j] && esel == 4'b0000) begin
            esel[j] = 1'b1;
            tgt     = j;
         end
      end
      if (!v) esel = 4'b0000;
      chk("in_rdy", 128'(in_rdy), 128'(|macc));
      chk("v_sel", 128'(v_sel), 128'(esel));
      last_sel = v_sel;
      for (int i = 0; i < 4; i++) begin
         if (esel[i]) begin
            mvld[i]            = 1'b1;
            mdata[i*32 +: 32]  = d;
         end else if (r[i]) begin
            mvld[i] = 1'b0;
         end
      end
      if (esel != 4'b0000) mptr = (tgt == 3) ? 0 : tgt + 1;
      @(posedge clk);
      #1;
      chk("out_vld", 128'(out_vld), 128'(mvld));
      chk("out_data", out_data, mdata);
   endtask

   initial begin
      logic [3:0] seq1 [8];
      logic [2:0] seq3 [6];
      seq1 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
      seq3 = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

      rst = 1'b1;
      in_vld = 1'b0; in_data = 32'h0; out_rdy = 4'b0000;
      in_vld2 = 1'b0; in_data2 = 8'h0; out_rdy2 = 3'b000;
      mvld = 4'b0000; mdata = 128'h0; mptr = 0; last_sel = 4'b0000;
      #1;
      chk("reset_out_vld", 128'(out_vld), 128'(4'b0000));
      chk("reset_out_data", out_data, 128'h0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("reset_in_rdy", 128'(in_rdy), 128'(1'b1));
      chk("reset_v_sel_idle", 128'(v_sel), 128'(4'b0000));
      @(posedge clk); #1;

      // 1: all ready, continuous input -> rotation 0,1,2,3,0,...
      for (int k = 0; k < 8; k++) begin
         cyc(1'b1, 32'h100 + 32'(k), 4'b1111);
         chk("t1_sel", 128'(last_sel), 128'(seq1[k]));
         chk("t1_vld", 128'(out_vld), 128'(seq1[k]));
      end

      // 2: drain, then fill all four with no consumer ready
      cyc(1'b0, 32'h0, 4'b1111);
      for (int k = 0; k < 4; k++) begin
         cyc(1'b1, 32'h200 + 32'(k), 4'b0000);
         chk("t2_fill_sel", 128'(last_sel), 128'(seq1[k]));
      end
      cyc(1'b1, 32'h2EE, 4'b0000);
      chk("t2_full_sel", 128'(last_sel), 128'(4'b0000));
      chk("t2_hold_data", out_data, 128'h00000203_00000202_00000201_00000200);
      // 2/4: port 2 drains and is refilled in the same cycle
      cyc(1'b1, 32'h2FF, 4'b0100);
      chk("t2_port2_sel", 128'(last_sel), 128'(4'b0100));
      chk("t4_vld_nobubble", 128'(out_vld), 128'(4'b1111));
      chk("t4_data2", 128'(out_data[95:64]), 128'(32'h2FF));

      // 3: skip non-ready ports; first bring ptr back to 0
      cyc(1'b1, 32'h300, 4'b1000);
      chk("t3_prep_sel", 128'(last_sel), 128'(4'b1000));
      cyc(1'b1, 32'h301, 4'b1010);
      chk("t3_skip_sel1", 128'(last_sel), 128'(4'b0010));
      cyc(1'b1, 32'h302, 4'b1010);
      chk("t3_skip_sel3", 128'(last_sel), 128'(4'b1000));
      cyc(1'b1, 32'h303, 4'b1111);
      chk("t3_ptr0_sel", 128'(last_sel), 128'(4'b0001));
      chk("t3_vld", 128'(out_vld), 128'(4'b0001));

      // 6: three slots full, ptr at 3, then async reset mid-stream
      cyc(1'b1, 32'h600, 4'b0000);
      chk("t6_fill1", 128'(last_sel), 128'(4'b0010));
      cyc(1'b1, 32'h601, 4'b0000);
      chk("t6_fill2", 128'(last_sel), 128'(4'b0100));
      chk("t6_vld_pre", 128'(out_vld), 128'(4'b0111));
      #2;
      rst = 1'b1;
      #1;
      chk("t6_async_vld", 128'(out_vld), 128'(4'b0000));
      chk("t6_async_data", out_data, 128'h0);
      mvld = 4'b0000; mdata = 128'h0; mptr = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      cyc(1'b1, 32'h610, 4'b0000);
      chk("t6_after_rst_sel", 128'(last_sel), 128'(4'b0001));

      // random out_rdy / in_vld soak against the model
      for (int k = 0; k < 300; k++) begin
         cyc(1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
      end
      cyc(1'b0, 32'h0, 4'b1111);
      chk("soak_drained", 128'(out_vld), 128'(4'b0000));

      // 5: WIDTH=3 instance, wrap on a non-power-of-two port count
      out_rdy2 = 3'b111;
      for (int k = 0; k < 6; k++) begin
         in_vld2  = 1'b1;
         in_data2 = 8'hA0 + 8'(k);
         #1;
         chk("t5_rdy", 128'(in_rdy2), 128'(1'b1));
         chk("t5_sel", 128'(v_sel2), 128'(seq3[k]));
         @(posedge clk); #1;
         chk("t5_vld", 128'(out_vld2), 128'(seq3[k]));
         chk("t5_data", 128'(out_data2[(k % 3)*8 +: 8]), 128'(8'hA0 + 8'(k)));
      end
      in_vld2 = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
